// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the RV32I control path: opcodes, immediate formats,
// result/PC select codes, ALU codes and the per-stage control word.
package riscv_ctrl_pkg;

    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_BR   = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111;
    localparam logic [6:0] OP_LUI  = 7'b0110111;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

    localparam logic [1:0] RES_ALU = 2'b00;
    localparam logic [1:0] RES_MEM = 2'b01;
    localparam logic [1:0] RES_PC4 = 2'b10;
    localparam logic [1:0] RES_IMM = 2'b11;

    localparam logic [1:0] PCSRC_PC4 = 2'b00;
    localparam logic [1:0] PCSRC_IMM = 2'b01;
    localparam logic [1:0] PCSRC_ALU = 2'b10;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    typedef enum logic [1:0] {
        ALU_MODE_ADD = 2'b00,
        ALU_MODE_SUB = 2'b01,
        ALU_MODE_F3  = 2'b10,
        ALU_MODE_BAD = 2'b11
    } alu_mode_e;

    typedef struct packed {
        logic       reg_write;
        logic [1:0] result_src;
        logic       mem_write;
        logic       jump;
        logic       jalr;
        logic       branch;
        logic       bne;
        logic       alu_src;
        logic       illegal;
    } ctrl_t;

endpackage

// File: rtl/pipelined_control_unit_alu_decoder.sv
// ALU decoder: maps ALU mode plus funct3/op[5]/funct7[5] onto an ALU control
// code, zero-extended to ALU_CTRL_W; anything unsupported yields ALU_BAD.
module alu_decoder
    import riscv_ctrl_pkg::*;
#(
    parameter int unsigned               ALU_CTRL_W = 3,
    parameter logic [ALU_CTRL_W-1:0]     ALU_BAD    = '1
) (
    input  logic [1:0]            alu_mode_i,
    input  logic [2:0]            funct3_i,
    input  logic                  op5_i,
    input  logic                  funct7b5_i,
    output logic [ALU_CTRL_W-1:0] alu_control_o
);

    always_comb begin
        alu_control_o = ALU_BAD;
        case (alu_mode_e'(alu_mode_i))
            ALU_MODE_ADD: alu_control_o = ALU_CTRL_W'(ALU_ADD);
            ALU_MODE_SUB: alu_control_o = ALU_CTRL_W'(ALU_SUB);
            ALU_MODE_F3: begin
                case (funct3_i)
                    // I-type addi never subtracts, even when instr[30] is set
                    3'b000:  alu_control_o = (op5_i & funct7b5_i) ? ALU_CTRL_W'(ALU_SUB)
                                                                  : ALU_CTRL_W'(ALU_ADD);
                    3'b010:  alu_control_o = ALU_CTRL_W'(ALU_SLT);
                    3'b110:  alu_control_o = ALU_CTRL_W'(ALU_OR);
                    3'b111:  alu_control_o = ALU_CTRL_W'(ALU_AND);
                    default: alu_control_o = ALU_BAD;
                endcase
            end
            default: alu_control_o = ALU_BAD;
        endcase
    end

endmodule

// File: rtl/pipelined_control_unit.sv
// RV32I main/ALU decoder with ID/EX, EX/MEM and MEM/WB control registers,
// EX-stage branch/jump resolution and a sticky illegal-opcode flag.
module pipelined_control_unit
    import riscv_ctrl_pkg::*;
#(
    parameter int unsigned           ALU_CTRL_W = 3,
    parameter logic [ALU_CTRL_W-1:0] ALU_BAD    = {ALU_CTRL_W{1'b1}},
    parameter logic                  EN_BNE     = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [6:0]            op_d,
    input  logic [2:0]            funct3_d,
    input  logic                  funct7b5_d,
    input  logic                  flush_e,
    input  logic                  zero_e,
    output logic [2:0]            imm_src_d,
    output logic [ALU_CTRL_W-1:0] alu_control_e,
    output logic                  alu_src_e,
    output logic [1:0]            pc_src_e,
    output logic [1:0]            result_src_e,
    output logic                  reg_write_m,
    output logic                  mem_write_m,
    output logic                  reg_write_w,
    output logic [1:0]            result_src_w,
    output logic                  illegal_o
);

    ctrl_t                  dec_ctrl;
    logic [1:0]             alu_mode;
    logic [ALU_CTRL_W-1:0]  dec_alu_control;

    ctrl_t                  id_ex_d,  id_ex_q;
    logic [ALU_CTRL_W-1:0]  alu_control_e_d, alu_control_e_q;
    logic                   reg_write_m_q, mem_write_m_q;
    logic [1:0]             result_src_m_q;
    logic                   reg_write_w_q;
    logic [1:0]             result_src_w_q;
    logic                   illegal_d, illegal_q;

    always_comb begin
        dec_ctrl  = '0;
        imm_src_d = IMM_I;
        alu_mode  = ALU_MODE_ADD;
        case (op_d)
            OP_LW: begin
                dec_ctrl.reg_write  = 1'b1;
                dec_ctrl.result_src = RES_MEM;
                dec_ctrl.alu_src    = 1'b1;
            end
            OP_SW: begin
                imm_src_d          = IMM_S;
                dec_ctrl.mem_write = 1'b1;
                dec_ctrl.alu_src   = 1'b1;
            end
            OP_R: begin
                dec_ctrl.reg_write = 1'b1;
                alu_mode           = ALU_MODE_F3;
            end
            OP_I: begin
                dec_ctrl.reg_write = 1'b1;
                dec_ctrl.alu_src   = 1'b1;
                alu_mode           = ALU_MODE_F3;
            end
            OP_BR: begin
                if (funct3_d == 3'b000 || (funct3_d == 3'b001 && EN_BNE)) begin
                    imm_src_d       = IMM_B;
                    dec_ctrl.branch = 1'b1;
                    dec_ctrl.bne    = funct3_d[0];
                    alu_mode        = ALU_MODE_SUB;
                end else begin
                    dec_ctrl.illegal = 1'b1;
                    alu_mode         = ALU_MODE_BAD;
                end
            end
            OP_JAL: begin
                imm_src_d           = IMM_J;
                dec_ctrl.reg_write  = 1'b1;
                dec_ctrl.result_src = RES_PC4;
                dec_ctrl.jump       = 1'b1;
            end
            OP_JALR: begin
                dec_ctrl.reg_write  = 1'b1;
                dec_ctrl.result_src = RES_PC4;
                dec_ctrl.jalr       = 1'b1;
                dec_ctrl.alu_src    = 1'b1;
            end
            OP_LUI: begin
                imm_src_d           = IMM_U;
                dec_ctrl.reg_write  = 1'b1;
                dec_ctrl.result_src = RES_IMM;
            end
            default: begin
                dec_ctrl.illegal = 1'b1;
                alu_mode         = ALU_MODE_BAD;
            end
        endcase
    end

    alu_decoder #(
        .ALU_CTRL_W (ALU_CTRL_W),
        .ALU_BAD    (ALU_BAD)
    ) u_alu_decoder (
        .alu_mode_i    (alu_mode),
        .funct3_i      (funct3_d),
        .op5_i         (op_d[5]),
        .funct7b5_i    (funct7b5_d),
        .alu_control_o (dec_alu_control)
    );

    // A flush overrides everything, including an illegal opcode sitting in ID
    always_comb begin
        id_ex_d         = flush_e ? '0 : dec_ctrl;
        alu_control_e_d = flush_e ? '0 : dec_alu_control;
        illegal_d       = illegal_q | id_ex_q.illegal;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            id_ex_q         <= '0;
            alu_control_e_q <= '0;
            reg_write_m_q   <= 1'b0;
            mem_write_m_q   <= 1'b0;
            result_src_m_q  <= '0;
            reg_write_w_q   <= 1'b0;
            result_src_w_q  <= '0;
            illegal_q       <= 1'b0;
        end else begin
            id_ex_q         <= id_ex_d;
            alu_control_e_q <= alu_control_e_d;
            reg_write_m_q   <= id_ex_q.reg_write;
            mem_write_m_q   <= id_ex_q.mem_write;
            result_src_m_q  <= id_ex_q.result_src;
            reg_write_w_q   <= reg_write_m_q;
            result_src_w_q  <= result_src_m_q;
            illegal_q       <= illegal_d;
        end
    end

    always_comb begin
        pc_src_e = PCSRC_PC4;
        if (id_ex_q.jalr) begin
            pc_src_e = PCSRC_ALU;
        end else if (id_ex_q.jump | (id_ex_q.branch & (zero_e ^ id_ex_q.bne))) begin
            pc_src_e = PCSRC_IMM;
        end
    end

    assign alu_control_e = alu_control_e_q;
    assign alu_src_e     = id_ex_q.alu_src;
    assign result_src_e  = id_ex_q.result_src;
    assign reg_write_m   = reg_write_m_q;
    assign mem_write_m   = mem_write_m_q;
    assign reg_write_w   = reg_write_w_q;
    assign result_src_w  = result_src_w_q;
    assign illegal_o     = illegal_q;

endmodule

// File: tb/tb_pipelined_control_unit.sv
// Scoreboard bench for pipelined_control_unit: expected control words are
// queued when an instruction is driven into ID and compared as they flow down.
module tb_pipelined_control_unit;

    logic       clk;
    logic       rst_n;
    logic [6:0] op_d;
    logic [2:0] funct3_d;
    logic       funct7b5_d;
    logic       flush_e;
    logic       zero_e;

    logic [2:0] imm_src_d;
    logic [2:0] alu_control_e;
    logic       alu_src_e;
    logic [1:0] pc_src_e;
    logic [1:0] result_src_e;
    logic       reg_write_m;
    logic       mem_write_m;
    logic       reg_write_w;
    logic [1:0] result_src_w;
    logic       illegal_o;

    logic [2:0] nb_imm_src_d;
    logic [2:0] nb_alu_control_e;
    logic       nb_alu_src_e;
    logic [1:0] nb_pc_src_e;
    logic [1:0] nb_result_src_e;
    logic       nb_reg_write_m;
    logic       nb_mem_write_m;
    logic       nb_reg_write_w;
    logic [1:0] nb_result_src_w;
    logic       nb_illegal_o;

    pipelined_control_unit dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .op_d          (op_d),
        .funct3_d      (funct3_d),
        .funct7b5_d    (funct7b5_d),
        .flush_e       (flush_e),
        .zero_e        (zero_e),
        .imm_src_d     (imm_src_d),
        .alu_control_e (alu_control_e),
        .alu_src_e     (alu_src_e),
        .pc_src_e      (pc_src_e),
        .result_src_e  (result_src_e),
        .reg_write_m   (reg_write_m),
        .mem_write_m   (mem_write_m),
        .reg_write_w   (reg_write_w),
        .result_src_w  (result_src_w),
        .illegal_o     (illegal_o)
    );

    pipelined_control_unit #(
        .EN_BNE (1'b0)
    ) dut_nb (
        .clk           (clk),
        .rst_n         (rst_n),
        .op_d          (op_d),
        .funct3_d      (funct3_d),
        .funct7b5_d    (funct7b5_d),
        .flush_e       (flush_e),
        .zero_e        (zero_e),
        .imm_src_d     (nb_imm_src_d),
        .alu_control_e (nb_alu_control_e),
        .alu_src_e     (nb_alu_src_e),
        .pc_src_e      (nb_pc_src_e),
        .result_src_e  (nb_result_src_e),
        .reg_write_m   (nb_reg_write_m),
        .mem_write_m   (nb_mem_write_m),
        .reg_write_w   (nb_reg_write_w),
        .result_src_w  (nb_result_src_w),
        .illegal_o     (nb_illegal_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic       rw;
        logic [1:0] rs;
        logic       mw;
        logic       jump;
        logic       jalr;
        logic       branch;
        logic       bne;
        logic       asrc;
        logic       ill;
        logic [2:0] alu;
        logic [2:0] imm;
        logic       z;
    } rec_t;

    rec_t sb[$];
    rec_t exp_e, exp_m, exp_w;
    logic ill_model;
    int   n_checks;
    int   n_pass;

    task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    endtask

    function automatic logic [2:0] model_alu_f3(input logic [2:0] f3, input logic sub_ok);
        case (f3)
            3'b000:  return sub_ok ? 3'd1 : 3'd0;
            3'b010:  return 3'd5;
            3'b110:  return 3'd3;
            3'b111:  return 3'd2;
            default: return 3'd7;
        endcase
    endfunction

    function automatic rec_t model(input logic [6:0] op, input logic [2:0] f3, input logic f7);
        rec_t r;
        r = '{default: '0};
        case (op)
            7'b0000011: begin r.rw = 1; r.rs = 2'b01; r.asrc = 1; end
            7'b0100011: begin r.mw = 1; r.asrc = 1; r.imm = 3'd1; end
            7'b0110011: begin r.rw = 1; r.alu = model_alu_f3(f3, f7); end
            7'b0010011: begin r.rw = 1; r.asrc = 1; r.alu = model_alu_f3(f3, 1'b0); end
            7'b1100011: begin
                if (f3 == 3'b000 || f3 == 3'b001) begin
                    r.branch = 1; r.bne = f3[0]; r.alu = 3'd1; r.imm = 3'd2;
                end else begin
                    r.ill = 1; r.alu = 3'd7;
                end
            end
            7'b1101111: begin r.rw = 1; r.rs = 2'b10; r.jump = 1; r.imm = 3'd3; end
            7'b1100111: begin r.rw = 1; r.rs = 2'b10; r.jalr = 1; r.asrc = 1; end
            7'b0110111: begin r.rw = 1; r.rs = 2'b11; r.imm = 3'd4; end
            default:    begin r.ill = 1; r.alu = 3'd7; end
        endcase
        return r;
    endfunction

    function automatic logic [1:0] model_pc(input rec_t r);
        if (r.jalr) return 2'b10;
        if (r.jump || (r.branch && (r.z ^ r.bne))) return 2'b01;
        return 2'b00;
    endfunction

    task automatic clear_model();
        exp_e = '{default: '0};
        exp_m = '{default: '0};
        exp_w = '{default: '0};
        sb.delete();
        ill_model = 1'b0;
    endtask

    // Called at a negedge; returns at the following negedge.
    task automatic step(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                        input logic fl, input logic z);
        rec_t r;
        op_d = op; funct3_d = f3; funct7b5_d = f7; flush_e = fl;
        r = model(op, f3, f7);
        #1;
        check_eq("imm_src_d", 8'(imm_src_d), 8'(r.imm));
        if (fl) r = '{default: '0};
        r.z = z;
        sb.push_back(r);
        @(posedge clk);
        #1;
        exp_w = exp_m;
        exp_m = exp_e;
        ill_model = ill_model | exp_e.ill;
        if (sb.size() == 0) begin
            n_checks++;
            $display("FAIL sb_pop: got empty queue expected one entry");
        end else begin
            exp_e = sb.pop_front();
        end
        zero_e = exp_e.z;
        #1;
        check_eq("alu_control_e", 8'(alu_control_e), 8'(exp_e.alu));
        check_eq("alu_src_e",     8'(alu_src_e),     8'(exp_e.asrc));
        check_eq("result_src_e",  8'(result_src_e),  8'(exp_e.rs));
        check_eq("pc_src_e",      8'(pc_src_e),      8'(model_pc(exp_e)));
        check_eq("reg_write_m",   8'(reg_write_m),   8'(exp_m.rw));
        check_eq("mem_write_m",   8'(mem_write_m),   8'(exp_m.mw));
        check_eq("reg_write_w",   8'(reg_write_w),   8'(exp_w.rw));
        check_eq("result_src_w",  8'(result_src_w),  8'(exp_w.rs));
        check_eq("illegal_o",     8'(illegal_o),     8'(ill_model));
        @(negedge clk);
    endtask

    task automatic check_reset(input string tag);
        check_eq({tag, "_alu"},    8'(alu_control_e), 8'h00);
        check_eq({tag, "_asrc"},   8'(alu_src_e),     8'h00);
        check_eq({tag, "_pc"},     8'(pc_src_e),      8'h00);
        check_eq({tag, "_res_e"},  8'(result_src_e),  8'h00);
        check_eq({tag, "_rw_m"},   8'(reg_write_m),   8'h00);
        check_eq({tag, "_mw_m"},   8'(mem_write_m),   8'h00);
        check_eq({tag, "_rw_w"},   8'(reg_write_w),   8'h00);
        check_eq({tag, "_res_w"},  8'(result_src_w),  8'h00);
        check_eq({tag, "_ill"},    8'(illegal_o),     8'h00);
        check_eq({tag, "_nb_ill"}, 8'(nb_illegal_o),  8'h00);
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        rst_n = 1'b0; op_d = '0; funct3_d = '0; funct7b5_d = 1'b0;
        flush_e = 1'b0; zero_e = 1'b0;
        clear_model();
        repeat (2) @(negedge clk);
        check_reset("rst_init");
        rst_n = 1'b1;

        step(7'b0110011, 3'b000, 1'b0, 1'b0, 1'b0); // add
        step(7'b0110011, 3'b000, 1'b1, 1'b0, 1'b0); // sub
        step(7'b0010011, 3'b000, 1'b1, 1'b0, 1'b0); // addi, instr[30]=1
        step(7'b0110011, 3'b010, 1'b0, 1'b0, 1'b0); // slt
        step(7'b0110011, 3'b110, 1'b0, 1'b0, 1'b0); // or
        step(7'b0010011, 3'b111, 1'b0, 1'b0, 1'b0); // andi
        step(7'b0110011, 3'b001, 1'b0, 1'b0, 1'b0); // sll: unsupported funct3
        step(7'b0000011, 3'b010, 1'b0, 1'b0, 1'b0); // lw
        step(7'b0100011, 3'b010, 1'b0, 1'b1, 1'b0); // sw flushed
        step(7'b0100011, 3'b010, 1'b0, 1'b0, 1'b0); // sw
        step(7'b1100011, 3'b000, 1'b0, 1'b0, 1'b1); // beq taken
        step(7'b1100011, 3'b000, 1'b0, 1'b0, 1'b0); // beq not taken
        step(7'b1100011, 3'b001, 1'b0, 1'b0, 1'b1); // bne not taken
        step(7'b1100011, 3'b001, 1'b0, 1'b0, 1'b0); // bne taken
        step(7'b1101111, 3'b000, 1'b0, 1'b0, 1'b0); // jal
        check_eq("nb_bne_illegal", 8'(nb_illegal_o), 8'h01);
        step(7'b1100111, 3'b000, 1'b0, 1'b0, 1'b1); // jalr
        step(7'b0110111, 3'b000, 1'b0, 1'b0, 1'b0); // lui
        step(7'b1111111, 3'b000, 1'b0, 1'b1, 1'b0); // illegal, flushed
        step(7'b0110011, 3'b000, 1'b0, 1'b0, 1'b0);
        step(7'b0110011, 3'b000, 1'b0, 1'b0, 1'b0);
        step(7'b1111111, 3'b000, 1'b0, 1'b0, 1'b0); // illegal
        for (int i = 0; i < 4; i++) step(7'b0110011, 3'b000, 1'b0, 1'b0, 1'b0);

        #2;
        rst_n = 1'b0;
        #1;
        check_reset("rst_mid");
        @(negedge clk);
        rst_n = 1'b1;
        clear_model();
        step(7'b0110011, 3'b000, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(7'b0010011, 3'b110, 1'b0, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
